// File: rtl/alu_result_pipe.sv
// EX->MEM result stage: 2-entry skid buffer (head H, skid S) carrying ALU result, flags and rd,
// with a forwarding tap on the head. Build with OVF_TRAP_EN to enable the overflow trap + trap_cnt.
module alu_result_pipe #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_c,
  input  logic          in_zero,
  input  logic          in_carry,
  input  logic          in_overflow,
  input  logic [3:0]    in_aluc,
  input  logic [RW-1:0] in_rd,
  input  logic          in_wen,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [RW-1:0] out_rd,
  output logic          out_wen,
  output logic          out_zero,
  output logic          out_carry,
  output logic          fwd_valid,
  output logic [RW-1:0] fwd_rd,
  output logic [DW-1:0] fwd_data,
  output logic          ovf_trap
`ifdef OVF_TRAP_EN
  ,
  output logic [7:0]    trap_cnt
`endif
);

  // Entry layout: {data, rd, wen, zero, carry}
  localparam int EW = DW + RW + 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [EW-1:0]  h_q, h_d;
  logic [EW-1:0]  s_q, s_d;
  logic [EW-1:0]  in_entry_s;
  logic           accept_s;
  logic           pop_s;
  logic           wen_s;
  logic           rd_nz_s;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept_s  = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;
  assign rd_nz_s   = (in_rd != {RW{1'b0}});

`ifdef OVF_TRAP_EN
  function automatic logic is_qual_ovf(input logic ovf, input logic [3:0] aluc);
    return ovf & ((aluc == 4'b0000) | (aluc == 4'b0010));
  endfunction

  logic       qual_ovf_s;
  logic       ovf_trap_q, ovf_trap_d;
  logic [7:0] trap_cnt_q, trap_cnt_d;

  assign qual_ovf_s = is_qual_ovf(in_overflow, in_aluc);
  assign wen_s      = in_wen & rd_nz_s & ~qual_ovf_s;

  // Trap pulse and saturating counter next-state
  always_comb begin
    ovf_trap_d = accept_s & qual_ovf_s;
    trap_cnt_d = trap_cnt_q;
    if (ovf_trap_d && (trap_cnt_q != 8'hFF)) begin
      trap_cnt_d = trap_cnt_q + 8'd1;
    end else begin
      trap_cnt_d = trap_cnt_q;
    end
  end

  // Trap registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_trap_q <= 1'b0;
      trap_cnt_q <= 8'd0;
    end else begin
      ovf_trap_q <= ovf_trap_d;
      trap_cnt_q <= trap_cnt_d;
    end
  end

  assign ovf_trap = ovf_trap_q;
  assign trap_cnt = trap_cnt_q;
`else
  logic ovf_unused_s;

  // Overflow and opcode only matter when the trap is built in
  assign ovf_unused_s = ^{in_overflow, in_aluc};
  assign wen_s        = in_wen & rd_nz_s;
  assign ovf_trap     = 1'b0;
`endif

  assign in_entry_s = {in_c, in_rd, wen_s, in_zero, in_carry};

  // Skid-buffer next state: FIFO order, H always holds the oldest entry
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          h_d     = in_entry_s;
          state_d = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && pop_s) begin
          h_d     = in_entry_s;
          state_d = ST_ONE;
        end else if (pop_s) begin
          state_d = ST_EMPTY;
        end else if (accept_s) begin
          s_d     = in_entry_s;
          state_d = ST_FULL;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_FULL: begin
        if (pop_s) begin
          h_d     = s_q;
          state_d = ST_ONE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Storage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      h_q     <= {EW{1'b0}};
      s_q     <= {EW{1'b0}};
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      s_q     <= s_d;
    end
  end

  assign out_data  = h_q[EW-1 -: DW];
  assign out_rd    = h_q[RW+2:3];
  assign out_wen   = h_q[2];
  assign out_zero  = h_q[1];
  assign out_carry = h_q[0];

  assign fwd_valid = out_valid & out_wen & (out_rd != {RW{1'b0}});
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_data;

endmodule
